// File: rtl/kmp_prefix_table.sv
// KMP prefix (LPS) table builder: loads the pattern from a synchronous ROM, then runs one
// LPS iteration per cycle. Optional iteration counter output enabled by KMP_PREFIX_STATS_EN.
module kmp_prefix_table #(
  parameter int PAT_LEN = 5,
  parameter int ADDR_W  = 3,
  parameter int DATA_W  = 8,
  parameter int LPS_W   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] pat_addr,
  input  logic [DATA_W-1:0] pat_data,
  input  logic [ADDR_W-1:0] query_idx,
  output logic [LPS_W-1:0]  query_val,
  output logic              busy,
  output logic              done,
`ifdef KMP_PREFIX_STATS_EN
  output logic [ADDR_W+1:0] iter_count,
`endif
  output logic [1:0]        actual_state
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0]     PL        = CW'(PAT_LEN);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_COMP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]     i_q, i_d;
  logic [CW-1:0]     len_q, len_d;
  logic [DATA_W-1:0] pat_q [PAT_LEN];
  logic [DATA_W-1:0] pat_d [PAT_LEN];
  logic [LPS_W-1:0]  lps_q [PAT_LEN];
  logic [LPS_W-1:0]  lps_d [PAT_LEN];
  logic [ADDR_W+1:0] iter_q, iter_d;

  logic [CW-1:0]     ld_m1, len_m1, len_p1, i_p1;
  logic [ADDR_W-1:0] i_idx, len_idx;

  assign ld_m1   = ld_cnt_q - 1'b1;
  assign len_m1  = len_q - 1'b1;
  assign len_p1  = len_q + 1'b1;
  assign i_p1    = i_q + 1'b1;
  assign i_idx   = i_q[ADDR_W-1:0];
  assign len_idx = len_q[ADDR_W-1:0];

  always_comb begin
    state_d  = state_q;
    ld_cnt_d = ld_cnt_q;
    i_d      = i_q;
    len_d    = len_q;
    pat_d    = pat_q;
    lps_d    = lps_q;
    iter_d   = iter_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        // A restart wipes the old table so nothing stale survives into the rebuild.
        if (start) begin
          state_d  = S_LOAD;
          ld_cnt_d = '0;
          i_d      = '0;
          len_d    = '0;
          lps_d    = '{default: '0};
          iter_d   = '0;
        end
      end
      S_LOAD: begin
        ld_cnt_d = ld_cnt_q + 1'b1;
        // ROM data lags the address by one cycle.
        if (ld_cnt_q != '0) pat_d[ld_m1[ADDR_W-1:0]] = pat_data;
        if (ld_cnt_q == PL) begin
          state_d  = S_COMP;
          i_d      = CW'(1);
          len_d    = '0;
          lps_d[0] = '0;
        end
      end
      S_COMP: begin
        if (i_q == PL) begin
          state_d = S_DONE;
        end else begin
          iter_d = iter_q + 1'b1;
          if (pat_q[i_idx] == pat_q[len_idx]) begin
            lps_d[i_idx] = LPS_W'(len_p1);
            len_d        = len_p1;
            i_d          = i_p1;
          end else if (len_q != '0) begin
            len_d = CW'(lps_q[len_m1[ADDR_W-1:0]]);
          end else begin
            lps_d[i_idx] = '0;
            i_d          = i_p1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      ld_cnt_q <= '0;
      i_q      <= '0;
      len_q    <= '0;
      pat_q    <= '{default: '0};
      lps_q    <= '{default: '0};
      iter_q   <= '0;
    end else begin
      state_q  <= state_d;
      ld_cnt_q <= ld_cnt_d;
      i_q      <= i_d;
      len_q    <= len_d;
      pat_q    <= pat_d;
      lps_q    <= lps_d;
      iter_q   <= iter_d;
    end
  end

  always_comb begin
    pat_addr = '0;
    if (state_q == S_LOAD)
      pat_addr = (ld_cnt_q < PL) ? ld_cnt_q[ADDR_W-1:0] : LAST_ADDR;
  end

  assign query_val    = ({1'b0, query_idx} < PL) ? lps_q[query_idx] : '0;
  assign busy         = (state_q == S_LOAD) || (state_q == S_COMP);
  assign done         = (state_q == S_DONE);
  assign actual_state = state_q;

`ifdef KMP_PREFIX_STATS_EN
  assign iter_count = iter_q;
`else
  logic unused_iter;
  assign unused_iter = ^iter_q;
`endif

endmodule

// File: tb/tb_kmp_prefix_table.sv
// Randomized self-checking bench for kmp_prefix_table: brute-force LPS reference model,
// per-cycle state/table compare, plus a PAT_LEN=1 instance.
module tb_kmp_prefix_table;

  typedef logic [4:0][7:0] pat_t;
  typedef logic [4:0][2:0] tab_t;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] pat_addr, query_idx, query_val;
  logic [7:0] pat_data;
  logic       busy, done;
  logic [1:0] st;
  logic [7:0] rom [8];

  logic       start1;
  logic [0:0] pat_addr1, query_idx1, query_val1;
  logic [7:0] pat_data1;
  logic       busy1, done1;
  logic [1:0] st1;
`ifdef KMP_PREFIX_STATS_EN
  logic [4:0] iter_count;
  logic [2:0] iter_count1;
`endif

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  kmp_prefix_table #(.PAT_LEN(5), .ADDR_W(3), .DATA_W(8), .LPS_W(3)) dut (
    .clk(clk), .rst(rst), .start(start), .pat_addr(pat_addr), .pat_data(pat_data),
    .query_idx(query_idx), .query_val(query_val), .busy(busy), .done(done),
`ifdef KMP_PREFIX_STATS_EN
    .iter_count(iter_count),
`endif
    .actual_state(st));

  kmp_prefix_table #(.PAT_LEN(1), .ADDR_W(1), .DATA_W(8), .LPS_W(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .pat_addr(pat_addr1), .pat_data(pat_data1),
    .query_idx(query_idx1), .query_val(query_val1), .busy(busy1), .done(done1),
`ifdef KMP_PREFIX_STATS_EN
    .iter_count(iter_count1),
`endif
    .actual_state(st1));

  always @(posedge clk) pat_data  <= rom[pat_addr];
  always @(posedge clk) pat_data1 <= 8'h5A;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Longest proper prefix that is also a suffix, by direct substring comparison.
  function automatic tab_t ref_lps(input pat_t p);
    tab_t t;
    for (int i = 0; i < 5; i++) begin
      int best = 0;
      for (int k = 1; k <= i; k++) begin
        bit ok = 1'b1;
        for (int j = 0; j < k; j++) if (p[j] != p[i-k+1+j]) ok = 1'b0;
        if (ok) best = k;
      end
      t[i] = best[2:0];
    end
    return t;
  endfunction

  // Number of classic KMP preprocessing iterations (advance or fall back).
  function automatic int ref_iters(input pat_t p);
    int l [5];
    int i = 1, len = 0, n = 0;
    l[0] = 0;
    while (i < 5) begin
      n++;
      if (p[i] == p[len]) begin len++; l[i] = len; i++; end
      else if (len != 0) len = l[len-1];
      else begin l[i] = 0; i++; end
    end
    return n;
  endfunction

  function automatic pat_t mk(input string s);
    pat_t p;
    for (int i = 0; i < 5; i++) p[i] = s[i];
    return p;
  endfunction

  // Timeline model: cycle c counts from the accepted start (cycle 1 = first LOAD cycle).
  pat_t       cur;
  logic       active;
  int         c, exp_n;
  tab_t       exp_tab;
  logic [1:0] exp_st;

  always_comb for (int k = 0; k < 5; k++) cur[k] = rom[k];

  always_comb begin
    if (!active)                 exp_st = 2'd0;
    else if (c <= 6)             exp_st = 2'd1;
    else if (c <= 7 + exp_n)     exp_st = 2'd2;
    else                         exp_st = 2'd3;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0; c <= 0; exp_n <= 0; exp_tab <= '0;
    end else if ((!active || exp_st == 2'd3) && start) begin
      active <= 1'b1; c <= 1; exp_n <= ref_iters(cur); exp_tab <= ref_lps(cur);
    end else if (active && c < 100000) begin
      c <= c + 1;
    end
  end

  always @(negedge clk) begin
    logic [2:0] sweep;
    sweep = query_idx + 3'd1;
    query_idx = sweep;
    #1;
    chk("state", {30'd0, st}, {30'd0, exp_st});
    chk("busy", {31'd0, busy}, {31'd0, exp_st == 2'd1 || exp_st == 2'd2});
    chk("done", {31'd0, done}, {31'd0, exp_st == 2'd3});
    if (rst) begin
      chk("rst_query", {29'd0, query_val}, 32'd0);
      chk("rst_pat_addr", {29'd0, pat_addr}, 32'd0);
    end else if (exp_st == 2'd1) begin
      chk("pat_addr", {29'd0, pat_addr}, (c - 1 < 5) ? c - 1 : 4);
    end else if (exp_st == 2'd3) begin
      if (query_idx < 3'd5) chk("query", {29'd0, query_val}, {29'd0, exp_tab[query_idx]});
      else                  chk("query_oob", {29'd0, query_val}, 32'd0);
`ifdef KMP_PREFIX_STATS_EN
      chk("iter_count", {27'd0, iter_count}, exp_n);
`endif
    end
  end

  task automatic load_rom(input pat_t p);
    for (int k = 0; k < 5; k++) rom[k] = p[k];
  endtask

  // Pulse start, optionally re-pulse it in cycles p1/p2, and measure the first done cycle.
  task automatic run(input pat_t p, input int exp_cyc, input int p1, input int p2);
    int cyc = 0;
    load_rom(p);
    @(negedge clk) start = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      start = (cyc == p1 || cyc == p2);
      if (done) break;
      if (cyc > 200) begin
        $display("FAIL done_timeout: got no done expected done by cycle %0d", exp_cyc);
        n_fail++;
        break;
      end
    end
    start = 1'b0;
    chk("done_cycle", cyc, exp_cyc);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    tab_t t;
    int   guard;
    int   cyc;
    pat_t rp;
    rst = 1'b1; start = 1'b0; start1 = 1'b0; query_idx = '0; query_idx1 = '0;
    for (int k = 0; k < 8; k++) rom[k] = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    chk("reset_state", {30'd0, st}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    rst = 1'b0;

    t = ref_lps(mk("ABABC")); chk("model_ababc", {17'd0, t}, {17'd0, 3'd0, 3'd2, 3'd1, 3'd0, 3'd0});
    chk("model_ababc_n", ref_iters(mk("ABABC")), 5);
    t = ref_lps(mk("AAAAA")); chk("model_aaaaa", {17'd0, t}, {17'd0, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0});
    chk("model_aaaaa_n", ref_iters(mk("AAAAA")), 4);
    t = ref_lps(mk("AABAA")); chk("model_aabaa", {17'd0, t}, {17'd0, 3'd2, 3'd1, 3'd0, 3'd1, 3'd0});
    t = ref_lps(mk("ABCAB")); chk("model_abcab", {17'd0, t}, {17'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0});

    run(mk("ABABC"), 13, -1, -1);
    run(mk("AAAAA"), 12, -1, -1);
    run(mk("AABAA"), 13, -1, -1);
    run(mk("ABCAB"), 12, -1, -1);
    run(mk("ABABC"), 13, 3, 9);

    // Asynchronous reset in the middle of COMPUTE.
    load_rom(mk("ABABC"));
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    guard = 0;
    while (st != 2'd2 && guard < 50) begin @(negedge clk); guard++; end
    chk("reached_compute", {30'd0, st}, 32'd2);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", {30'd0, st}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_addr", {29'd0, pat_addr}, 32'd0);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    run(mk("ABABC"), 13, -1, -1);

    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < 5; k++) rp[k] = 8'h41 + 8'($urandom_range(0, 2));
      run(rp, 8 + ref_iters(rp), (r % 2 == 1) ? int'($urandom_range(1, 11)) : -1, -1);
    end

    // PAT_LEN=1: LOAD in cycles 1-2, exit cycle 3, done in cycle 4.
    @(negedge clk) start1 = 1'b1;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start1 = 1'b0;
      if (cyc <= 2)      chk("p1_load", {30'd0, st1}, 32'd1);
      else if (cyc == 3) chk("p1_compute", {30'd0, st1}, 32'd2);
      if (done1 || cyc > 20) break;
    end
    chk("p1_done_cycle", cyc, 4);
    query_idx1 = 1'b0;
    #1 chk("p1_lps0", {31'd0, query_val1}, 32'd0);
    query_idx1 = 1'b1;
    #1 chk("p1_oob", {31'd0, query_val1}, 32'd0);
`ifdef KMP_PREFIX_STATS_EN
    chk("p1_iter", {29'd0, iter_count1}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
